// File: rtl/upb_seq_pkg.sv
// Shared definitions for the UPB tap sequencer slice.
// Holds tap count, word width, FSM encoding and tap index width.
package upb_seq_pkg;

    localparam int NTAPS = 6;
    localparam int CW    = 16;
    localparam int KW    = 3;

    localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SHIFT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/upb_tap_sequencer_upb.sv
// UPB: one zero-predictor coefficient update BnP = Bn + UGBn - ULBn.
// Ports: Bn_i, DQn_i (sign-mag), Un_i, rate_i -> BnP_o; scan feedthrough.
module upb_tap_sequencer_upb
    import upb_seq_pkg::*;
(
    input  logic [CW-1:0] Bn_i,
    input  logic [CW-1:0] DQn_i,
    input  logic          Un_i,
    input  logic [1:0]    rate_i,
    output logic [CW-1:0] BnP_o,
    input  logic          scan_in0,
    input  logic          scan_in1,
    input  logic          scan_in2,
    input  logic          scan_in3,
    input  logic          scan_in4,
    input  logic          scan_enable,
    input  logic          test_mode,
    output logic          scan_out0,
    output logic          scan_out1,
    output logic          scan_out2,
    output logic          scan_out3,
    output logic          scan_out4
);

    logic          mag_nz;
    logic [CW-1:0] ugb;
    logic [CW-1:0] ulb;
    logic          scan_path;

    // Gain is +/-128 only when the difference magnitude is nonzero.
    assign mag_nz = |DQn_i[CW-2:0];
    assign ugb    = !mag_nz ? '0 :
                    (Un_i ? 16'hFF80 : 16'h0080);

    // Leak is Bn arithmetically shifted; rate 00 uses the slower leak.
    assign ulb = (rate_i == 2'b00) ?
                 {{9{Bn_i[CW-1]}}, Bn_i[CW-1:9]} :
                 {{8{Bn_i[CW-1]}}, Bn_i[CW-1:8]};

    assign BnP_o = Bn_i + ugb - ulb;

    // Purely combinational block: the chain passes straight through.
    assign scan_path = scan_enable & test_mode;
    assign scan_out0 = scan_path & scan_in0;
    assign scan_out1 = scan_path & scan_in1;
    assign scan_out2 = scan_path & scan_in2;
    assign scan_out3 = scan_path & scan_in3;
    assign scan_out4 = scan_path & scan_in4;

endmodule

// File: rtl/upb_tap_sequencer.sv
// Sixth-order zero-predictor state: B1..B6 and DQ1..DQ6, one UPB shared.
// Ports: start/DQn/rate_in/tr in; busy/done/B_bus/DQH_bus out; scan chain.
// Optional macro TRIGB_EN: latched tr=1 clears B instead of updating.
module upb_tap_sequencer
    import upb_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CW-1:0]       DQn,
    input  logic [1:0]          rate_in,
    input  logic                tr,
    output logic                busy,
    output logic                done,
    output logic [NTAPS*CW-1:0] B_bus,
    output logic [NTAPS*CW-1:0] DQH_bus,
    input  logic                scan_in0,
    input  logic                scan_in1,
    input  logic                scan_in2,
    input  logic                scan_in3,
    input  logic                scan_in4,
    input  logic                scan_enable,
    input  logic                test_mode,
    output logic                scan_out0,
    output logic                scan_out1,
    output logic                scan_out2,
    output logic                scan_out3,
    output logic                scan_out4
);

    seq_state_e                 state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic                       done_q, done_d;
    logic [CW-1:0]              dq_q;
    logic [1:0]                 rate_q;
    logic [NTAPS-1:0][CW-1:0]   b_q;
    logic [NTAPS-1:0][CW-1:0]   dqh_q;

    logic                       latch;
    logic                       b_we;
    logic                       shift;
    logic [CW-1:0]              bn;
    logic                       hsign;
    logic                       un;
    logic [CW-1:0]              bnp;
    logic [CW-1:0]              b_wr;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        done_d  = 1'b0;
        latch   = 1'b0;
        b_we    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    latch   = 1'b1;
                    k_d     = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                b_we = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = SHIFT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            SHIFT: begin
                shift   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the current tap's coefficient and history sign.
    always_comb begin
        bn    = '0;
        hsign = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            if (k_q == KW'(i)) begin
                bn    = b_q[i];
                hsign = dqh_q[i][CW-1];
            end
        end
    end

    // A zero history word carries sign 0, so plain sign XOR suffices.
    assign un = dq_q[CW-1] ^ hsign;

    upb_tap_sequencer_upb u_upb (
        .Bn_i        (bn),
        .DQn_i       (dq_q),
        .Un_i        (un),
        .rate_i      (rate_q),
        .BnP_o       (bnp),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4)
    );

`ifdef TRIGB_EN
    logic tr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tr_q <= 1'b0;
        end else if (latch) begin
            tr_q <= tr;
        end
    end

    assign b_wr = tr_q ? '0 : bnp;
`else
    logic unused_tr;

    assign unused_tr = tr;
    assign b_wr      = bnp;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            done_q  <= 1'b0;
            dq_q    <= '0;
            rate_q  <= '0;
            b_q     <= '0;
            dqh_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            done_q  <= done_d;
            if (latch) begin
                dq_q   <= DQn;
                rate_q <= rate_in;
            end
            for (int i = 0; i < NTAPS; i++) begin
                if (b_we && (k_q == KW'(i))) begin
                    b_q[i] <= b_wr;
                end
            end
            if (shift) begin
                dqh_q <= {dqh_q[NTAPS-2:0], dq_q};
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign B_bus   = b_q;
    assign DQH_bus = dqh_q;

endmodule

// File: tb/tb_upb_tap_sequencer.sv
// Directed bench for upb_tap_sequencer.
// Hand-computed B/DQH vectors, latency, busy-start and reset checks.
module tb_upb_tap_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] DQn;
    logic [1:0]  rate_in;
    logic        tr;
    logic        busy;
    logic        done;
    logic [95:0] B_bus;
    logic [95:0] DQH_bus;
    logic        so0, so1, so2, so3, so4;

    int tests;
    int fails;

    upb_tap_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .DQn         (DQn),
        .rate_in     (rate_in),
        .tr          (tr),
        .busy        (busy),
        .done        (done),
        .B_bus       (B_bus),
        .DQH_bus     (DQH_bus),
        .scan_in0    (1'b0),
        .scan_in1    (1'b0),
        .scan_in2    (1'b0),
        .scan_in3    (1'b0),
        .scan_in4    (1'b0),
        .scan_enable (1'b0),
        .test_mode   (1'b0),
        .scan_out0   (so0),
        .scan_out1   (so1),
        .scan_out2   (so2),
        .scan_out3   (so3),
        .scan_out4   (so4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs,
                         input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_sample(input string tag, input logic [15:0] dq,
                              input logic [1:0] rt, input logic trv,
                              input bit inject);
        int lat;
        int nd;
        @(negedge clk);
        DQn     = dq;
        rate_in = rt;
        tr      = trv;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        DQn     = 16'h7FFF;
        rate_in = 2'b11;
        tr      = ~trv;
        check({tag, "_busy"}, 96'(busy), 96'd1);
        lat = 0;
        nd  = 0;
        for (int n = 1; n <= 10; n++) begin
            if (inject && (n == 2 || n == 5)) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (lat == 0) lat = n + 1;
            end
        end
        check({tag, "_latency"}, 96'(lat), 96'd8);
        check({tag, "_ndone"}, 96'(nd), 96'd1);
        check({tag, "_idle"}, 96'(busy), 96'd0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b0;
        start   = 1'b0;
        DQn     = '0;
        rate_in = '0;
        tr      = 1'b0;
        #12;
        check("rst_B", B_bus, '0);
        check("rst_DQH", DQH_bus, '0);
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_done", 96'(done), 96'd0);
        @(negedge clk);
        reset = 1'b1;

        run_sample("t1", 16'h0000, 2'b00, 1'b0, 1'b0);
        check("t1_B", B_bus, '0);
        check("t1_DQH", DQH_bus, '0);

        do_reset();
        run_sample("t2", 16'h0010, 2'b00, 1'b0, 1'b0);
        check("t2_B", B_bus, {6{16'h0080}});
        check("t2_DQH", DQH_bus, {80'h0, 16'h0010});

        run_sample("t3", 16'h8010, 2'b00, 1'b0, 1'b0);
        check("t3_B", B_bus, '0);
        check("t3_DQH", DQH_bus, {64'h0, 16'h0010, 16'h8010});

        run_sample("t3b", 16'h0020, 2'b00, 1'b0, 1'b0);
        check("t3b_B", B_bus,
              {16'h0080, 16'h0080, 16'h0080,
               16'h0080, 16'h0080, 16'hFF80});
        check("t3b_DQH", DQH_bus,
              {48'h0, 16'h0010, 16'h8010, 16'h0020});

        run_sample("t3c", 16'h8001, 2'b01, 1'b0, 1'b0);
        check("t3c_B", B_bus,
              {16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h0100, 16'hFF01});
        check("t3c_DQH", DQH_bus,
              {32'h0, 16'h0010, 16'h8010, 16'h0020, 16'h8001});

        do_reset();
        run_sample("t4a", 16'h0010, 2'b00, 1'b0, 1'b0);
        run_sample("t4b", 16'h0010, 2'b00, 1'b0, 1'b0);
        check("t4_B100", B_bus, {6{16'h0100}});
        run_sample("t4c", 16'h0010, 2'b01, 1'b0, 1'b0);
        check("t4_B1", 96'(B_bus[15:0]), 96'h017F);
        check("t4_B", B_bus, {6{16'h017F}});
        check("t4_DQH", DQH_bus,
              {48'h0, 16'h0010, 16'h0010, 16'h0010});

        run_sample("t5", 16'h8010, 2'b00, 1'b0, 1'b1);
        check("t5_B", B_bus, {6{16'h00FF}});
        check("t5_DQH", DQH_bus,
              {32'h0, 16'h0010, 16'h0010, 16'h0010, 16'h8010});

        @(negedge clk);
        DQn   = 16'h0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t5r_B", B_bus, '0);
        check("t5r_DQH", DQH_bus, '0);
        check("t5r_busy", 96'(busy), 96'd0);
        check("t5r_done", 96'(done), 96'd0);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            check("t5r_nodone", 96'(done), 96'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5r_after_B", B_bus, '0);
        check("t5r_after_done", 96'(done), 96'd0);

        run_sample("t6a", 16'h0010, 2'b00, 1'b0, 1'b0);
        run_sample("t6b", 16'h0010, 2'b00, 1'b1, 1'b0);
`ifdef TRIGB_EN
        check("t6_B", B_bus, '0);
`else
        check("t6_B", B_bus, {6{16'h0100}});
`endif
        check("t6_DQH", DQH_bus, {64'h0, 16'h0010, 16'h0010});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/upb_tap_sequencer.md
Name: upb_tap_sequencer

Overview:
- Owns the sixth-order zero-predictor state: coefficients B1..B6 and the quantized-difference history DQ1..DQ6.
- Per sample, it time-multiplexes one UPB instance across the six taps and forms each tap's Un.
- It writes back each BnP and then shifts the new DQ into the history.
- It feeds the zero-predictor accumulation stage (FMULT/ACCUM) with updated coefficients and history.

Parameters:
- NTAPS, 6, number of B taps/history entries; fixed by G.726, other values unsupported.
- CW, 16, coefficient and DQ word width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  one-cycle request to process one sample
- DQn  input  16  new quantized difference, sign-magnitude (bit15 sign, [14:0] magnitude)
- rate_in  input  2  rate select passed to UPB (00 selects the slower leak)
- tr  input  1  transition trigger; used only when TRIGB_EN is defined
- busy  output  1  high while a sample is being processed
- done  output  1  one-cycle pulse when B and DQ history are updated
- B_bus  output  96  B1..B6, B1 in [15:0], two's complement
- DQH_bus  output  96  DQ1..DQ6, DQ1 in [15:0], sign-magnitude
- scan_in0..scan_in4  input  1 each  scan chain inputs
- scan_enable, test_mode  input  1 each  DFT controls
- scan_out0..scan_out4  output  1 each  scan chain outputs

Behaviour:
- Reset values (asynchronous, reset=0): all B = 0x0000, all DQH = 0x0000, busy = 0, done = 0, state = IDLE, tap index = 0.
- States:
  - IDLE: on start=1 at edge E0, latch DQn, rate_in and tr; go to UPDATE with k=0; busy=1.
  - UPDATE: each cycle presents Bn=B[k], DQn=latched DQ and Un to UPB.
    - Un = latched_DQ[15] XOR DQH[k][15]; a zero history value has sign 0 (positive).
    - At the next edge, B[k] <= BnP and k increments.
    - B1 is written at E1 and B6 at E6; after k=5 go to SHIFT.
  - SHIFT: at E7, DQH[5..1] <= DQH[4..0] and DQH[0] <= latched DQ (stored as-is, sign-magnitude). Set done=1 and busy=0; go to IDLE.
  - done is registered and high for exactly the cycle after E7.
- Latency: start to done is 8 clocks; a new start is accepted in the cycle done is high.
- start while busy=1 is ignored; no queuing, latched inputs are unchanged.
- DQn and rate_in may change after E0 without effect on the sample in progress.
- Arithmetic is performed in UPB, modulo 2^16 wrap, no saturation. The sequencer does no arithmetic beyond Un and the index increment.
- Reset mid-operation: everything returns to reset values immediately, including partially updated B. No done pulse is produced.
- Outputs hold stable between samples; B_bus changes one tap per cycle during UPDATE. Consumers must sample B_bus and DQH_bus only on done.

Optional Feature:
- Macro TRIGB_EN.
- When defined:
  - If the latched tr=1, each UPDATE cycle writes B[k] <= 0x0000 instead of BnP.
  - The DQ history shift still occurs; latency is unchanged.
- When undefined: the tr port exists but is ignored; B is always written from BnP.

Decomposition:
- Shared package upb_seq_pkg holds:
  - NTAPS and CW
  - state encoding IDLE=2'd0, UPDATE=2'd1, SHIFT=2'd2
  - the tap index width (3 bits)
- One sub-module: the existing UPB block, instantiated once as u_upb, with scan ports chained through.

Test Plan:
1. Reset -> B_bus=0, DQH_bus=0, busy=0, done=0. Start with DQn=0x0000, rate_in=00 -> done at cycle 8; all B stay 0x0000; DQH1=0x0000.
2. From reset, start DQn=0x0010 -> Un=0 on all taps; all B=0x0080; DQH1=0x0010; done exactly 8 cycles after start.
3. Follow with start DQn=0x8010, rate_in=00 -> all Un=1 (DQH1 positive, others zero); all B=0x0000; DQH1=0x8010, DQH2=0x0010.
4. Leak check: drive to B=0x0100 (two samples of DQn=0x0010 from reset), then start DQn=0x0010 with rate_in=01 -> B1=0x017F.
5. Assert start again at cycles 2 and 5 while busy -> ignored; single done; results unchanged. Assert reset at cycle 4 -> all outputs return to reset values asynchronously; no done.
6. TRIGB_EN defined, B nonzero, start with tr=1 -> all B=0x0000 after done; DQ history still shifts. Without the macro, the same stimulus performs a normal update.
